// File: rtl/mppt_fitness_eval.sv
// Fitness evaluator for the PSO MPPT loop: drives a candidate duty, lets the PV
// operating point settle, averages 2^AVG_LOG2 ADC samples and reports P = avg(u)*avg(i).
module mppt_fitness_eval #(
    parameter int ADC_W      = 12,
    parameter int DUTY_W     = 10,
    parameter int N_PART     = 5,
    parameter int IDX_W      = 3,
    parameter int AVG_LOG2   = 3,
    parameter int SETTLE_CYC = 1000,
    parameter int DUTY_INIT  = 0
) (
    input  logic                 clk_P,
    input  logic                 rst_n,
    input  logic                 cand_valid,
    output logic                 cand_ready,
    input  logic [IDX_W-1:0]     cand_idx,
    input  logic [DUTY_W-1:0]    cand_duty,
    input  logic                 clr_best,
    input  logic                 adc_vld,
    input  logic [ADC_W-1:0]     u_in,
    input  logic [ADC_W-1:0]     i_in,
    output logic [DUTY_W-1:0]    duty_out,
    output logic                 busy,
    output logic                 res_valid,
    output logic [IDX_W-1:0]     res_idx,
    output logic [DUTY_W-1:0]    res_duty,
    output logic [2*ADC_W-1:0]   res_power,
    output logic                 idx_err,
    output logic                 gbest_valid,
    output logic [2*ADC_W-1:0]   gbest_power,
    output logic [DUTY_W-1:0]    gbest_duty,
    output logic [IDX_W-1:0]     gbest_idx
);

    localparam int SUM_W  = ADC_W + AVG_LOG2;
    localparam int PWR_W  = 2 * ADC_W;
    localparam int SCNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int ACNT_W = AVG_LOG2 + 1;

    localparam logic [SCNT_W-1:0] SETTLE_LAST = SCNT_W'(SETTLE_CYC - 1);
    localparam logic [ACNT_W-1:0] ACC_LAST    = ACNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [IDX_W:0]    N_PART_LIM  = (IDX_W + 1)'(N_PART);
    localparam logic [DUTY_W-1:0] DUTY_RST    = DUTY_W'(DUTY_INIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_ACC,
        S_MUL,
        S_OUT
    } state_t;

    state_t              state_q, state_d;
    logic [DUTY_W-1:0]   duty_out_q, duty_out_d;
    logic [IDX_W-1:0]    cur_idx_q, cur_idx_d;
    logic [DUTY_W-1:0]   cur_duty_q, cur_duty_d;
    logic [SCNT_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic [ACNT_W-1:0]   acc_cnt_q, acc_cnt_d;
    logic [SUM_W-1:0]    sum_u_q, sum_u_d;
    logic [SUM_W-1:0]    sum_i_q, sum_i_d;
    logic [IDX_W-1:0]    res_idx_q, res_idx_d;
    logic [DUTY_W-1:0]   res_duty_q, res_duty_d;
    logic [PWR_W-1:0]    res_power_q, res_power_d;
    logic                idx_err_q, idx_err_d;
    logic                gbest_valid_q, gbest_valid_d;
    logic [PWR_W-1:0]    gbest_power_q, gbest_power_d;
    logic [DUTY_W-1:0]   gbest_duty_q, gbest_duty_d;
    logic [IDX_W-1:0]    gbest_idx_q, gbest_idx_d;

    logic [ADC_W-1:0]    avg_u;
    logic [ADC_W-1:0]    avg_i;
    logic [PWR_W-1:0]    product;
    logic                idx_bad;

    // Averaging is a plain truncating shift: drop the low AVG_LOG2 bits of the sums.
    assign avg_u   = sum_u_q[SUM_W-1:AVG_LOG2];
    assign avg_i   = sum_i_q[SUM_W-1:AVG_LOG2];
    assign product = PWR_W'(avg_u) * PWR_W'(avg_i);
    assign idx_bad = ({1'b0, cand_idx} >= N_PART_LIM);

    always_comb begin
        state_d       = state_q;
        duty_out_d    = duty_out_q;
        cur_idx_d     = cur_idx_q;
        cur_duty_d    = cur_duty_q;
        settle_cnt_d  = settle_cnt_q;
        acc_cnt_d     = acc_cnt_q;
        sum_u_d       = sum_u_q;
        sum_i_d       = sum_i_q;
        res_idx_d     = res_idx_q;
        res_duty_d    = res_duty_q;
        res_power_d   = res_power_q;
        idx_err_d     = 1'b0;
        gbest_valid_d = gbest_valid_q;
        gbest_power_d = gbest_power_q;
        gbest_duty_d  = gbest_duty_q;
        gbest_idx_d   = gbest_idx_q;

        case (state_q)
            S_IDLE: begin
                if (cand_valid) begin
                    if (idx_bad) begin
                        idx_err_d = 1'b1;
                    end else begin
                        cur_idx_d    = cand_idx;
                        cur_duty_d   = cand_duty;
                        duty_out_d   = cand_duty;
                        settle_cnt_d = '0;
                        acc_cnt_d    = '0;
                        sum_u_d      = '0;
                        sum_i_d      = '0;
                        state_d      = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = S_ACC;
                end else begin
                    settle_cnt_d = settle_cnt_q + SCNT_W'(1);
                end
            end
            S_ACC: begin
                if (adc_vld) begin
                    sum_u_d   = sum_u_q + SUM_W'(u_in);
                    sum_i_d   = sum_i_q + SUM_W'(i_in);
                    acc_cnt_d = acc_cnt_q + ACNT_W'(1);
                    if (acc_cnt_q == ACC_LAST) begin
                        state_d = S_MUL;
                    end
                end
            end
            S_MUL: begin
                res_power_d = product;
                res_idx_d   = cur_idx_q;
                res_duty_d  = cur_duty_q;
                state_d     = S_OUT;
            end
            S_OUT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A clear issued in the same cycle as a result discards that result.
        if (clr_best) begin
            gbest_valid_d = 1'b0;
            gbest_power_d = '0;
            gbest_duty_d  = '0;
            gbest_idx_d   = '0;
        end else if ((state_q == S_OUT) && (!gbest_valid_q || (res_power_q > gbest_power_q))) begin
            gbest_valid_d = 1'b1;
            gbest_power_d = res_power_q;
            gbest_duty_d  = res_duty_q;
            gbest_idx_d   = res_idx_q;
        end
    end

    always_ff @(posedge clk_P) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            duty_out_q    <= DUTY_RST;
            cur_idx_q     <= '0;
            cur_duty_q    <= '0;
            settle_cnt_q  <= '0;
            acc_cnt_q     <= '0;
            sum_u_q       <= '0;
            sum_i_q       <= '0;
            res_idx_q     <= '0;
            res_duty_q    <= '0;
            res_power_q   <= '0;
            idx_err_q     <= 1'b0;
            gbest_valid_q <= 1'b0;
            gbest_power_q <= '0;
            gbest_duty_q  <= '0;
            gbest_idx_q   <= '0;
        end else begin
            state_q       <= state_d;
            duty_out_q    <= duty_out_d;
            cur_idx_q     <= cur_idx_d;
            cur_duty_q    <= cur_duty_d;
            settle_cnt_q  <= settle_cnt_d;
            acc_cnt_q     <= acc_cnt_d;
            sum_u_q       <= sum_u_d;
            sum_i_q       <= sum_i_d;
            res_idx_q     <= res_idx_d;
            res_duty_q    <= res_duty_d;
            res_power_q   <= res_power_d;
            idx_err_q     <= idx_err_d;
            gbest_valid_q <= gbest_valid_d;
            gbest_power_q <= gbest_power_d;
            gbest_duty_q  <= gbest_duty_d;
            gbest_idx_q   <= gbest_idx_d;
        end
    end

    assign cand_ready  = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign res_valid   = (state_q == S_OUT);
    assign duty_out    = duty_out_q;
    assign res_idx     = res_idx_q;
    assign res_duty    = res_duty_q;
    assign res_power   = res_power_q;
    assign idx_err     = idx_err_q;
    assign gbest_valid = gbest_valid_q;
    assign gbest_power = gbest_power_q;
    assign gbest_duty  = gbest_duty_q;
    assign gbest_idx   = gbest_idx_q;

endmodule
